// File: rtl/shapes_pkg.sv
// Shared constants for the rectangle shape engine: widths, field codes,
// rectangle 0 reset defaults and a saturating velocity negate.
package shapes_pkg;

  localparam int XW = 10;
  localparam int YW = 9;
  localparam int CW = 12;
  localparam int VW = 4;

  localparam logic [2:0] FIELD_X0    = 3'd0;
  localparam logic [2:0] FIELD_Y0    = 3'd1;
  localparam logic [2:0] FIELD_W     = 3'd2;
  localparam logic [2:0] FIELD_H     = 3'd3;
  localparam logic [2:0] FIELD_COLOR = 3'd4;
  localparam logic [2:0] FIELD_VEL   = 3'd5;
  localparam logic [2:0] FIELD_EN    = 3'd6;

  localparam logic [XW-1:0] RECT0_X0    = 10'd100;
  localparam logic [YW-1:0] RECT0_Y0    = 9'd200;
  localparam logic [XW-1:0] RECT0_W     = 10'd100;
  localparam logic [YW-1:0] RECT0_H     = 9'd100;
  localparam logic [CW-1:0] RECT0_COLOR = 12'hFA4;

  // -8 has no positive counterpart in 4 bits, so it flips to +7 instead
  function automatic logic signed [VW-1:0] neg_sat(input logic signed [VW-1:0] v);
    if (v == 4'sb1000) begin
      return 4'sd7;
    end
    return -v;
  endfunction

endpackage

// File: rtl/shape_engine_if.sv
// Pixel, frame and configuration signals of the shape engine, plus its
// colour/hit outputs. The driver uses master, the engine uses slave.
interface shape_engine_if;
  import shapes_pkg::*;

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          frame_tick;
  logic          cfg_we;
  logic [2:0]    cfg_idx;
  logic [2:0]    cfg_field;
  logic [CW-1:0] cfg_data;
  logic [3:0]    r;
  logic [3:0]    g;
  logic [3:0]    b;
  logic          hit;

  modport master (
    output x, y, frame_tick, cfg_we, cfg_idx, cfg_field, cfg_data,
    input  r, g, b, hit
  );

  modport slave (
    input  x, y, frame_tick, cfg_we, cfg_idx, cfg_field, cfg_data,
    output r, g, b, hit
  );

endinterface

// File: rtl/shape_rect.sv
// One rectangle: its registers, config decode, per-frame bounce motion and
// the stage-1 coverage flop for the current pixel.
module shape_rect
  import shapes_pkg::*;
#(
  parameter int IDX   = 0,
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  input  logic          frame_tick,
  input  logic          cfg_we,
  input  logic [2:0]    cfg_idx,
  input  logic [2:0]    cfg_field,
  input  logic [CW-1:0] cfg_data,
  output logic          hit_s1,
  output logic [CW-1:0] color
);

  localparam logic [XW-1:0] RST_X0    = (IDX == 0) ? RECT0_X0 : '0;
  localparam logic [YW-1:0] RST_Y0    = (IDX == 0) ? RECT0_Y0 : '0;
  localparam logic [XW-1:0] RST_W     = (IDX == 0) ? RECT0_W : '0;
  localparam logic [YW-1:0] RST_H     = (IDX == 0) ? RECT0_H : '0;
  localparam logic [CW-1:0] RST_COLOR = (IDX == 0) ? RECT0_COLOR : '0;
  localparam logic          RST_EN    = (IDX == 0);

  localparam logic signed [12:0] H_LIM = 13'(H_RES);
  localparam logic signed [12:0] V_LIM = 13'(V_RES);

  logic [XW-1:0]        x0;
  logic [YW-1:0]        y0;
  logic [XW-1:0]        w;
  logic [YW-1:0]        h;
  logic [CW-1:0]        color_q;
  logic signed [VW-1:0] dx;
  logic signed [VW-1:0] dy;
  logic                 en;

  logic                 wr_sel;
  logic signed [12:0]   nx;
  logic signed [12:0]   ny;
  logic signed [12:0]   w_s;
  logic signed [12:0]   h_s;
  logic [XW-1:0]        x0_mv;
  logic [YW-1:0]        y0_mv;
  logic signed [VW-1:0] dx_mv;
  logic signed [VW-1:0] dy_mv;
  logic                 cover_x;
  logic                 cover_y;

  assign wr_sel = cfg_we && (cfg_idx == 3'(IDX)) && (cfg_field <= FIELD_EN);
  assign w_s    = $signed({3'b000, w});
  assign h_s    = $signed({4'b0000, h});
  assign color  = color_q;

  // Candidate position/velocity after one frame of motion, with edge bounce
  always_comb begin
    nx    = $signed({3'b000, x0}) + $signed({{9{dx[VW-1]}}, dx});
    ny    = $signed({4'b0000, y0}) + $signed({{9{dy[VW-1]}}, dy});
    x0_mv = x0;
    dx_mv = dx;
    y0_mv = y0;
    dy_mv = dy;
    if (w_s > H_LIM) begin
      x0_mv = x0;
    end else if (nx < 0) begin
      x0_mv = '0;
      dx_mv = neg_sat(dx);
    end else if (nx + w_s > H_LIM) begin
      x0_mv = XW'(H_LIM - w_s);
      dx_mv = neg_sat(dx);
    end else begin
      x0_mv = nx[XW-1:0];
    end
    if (h_s > V_LIM) begin
      y0_mv = y0;
    end else if (ny < 0) begin
      y0_mv = '0;
      dy_mv = neg_sat(dy);
    end else if (ny + h_s > V_LIM) begin
      y0_mv = YW'(V_LIM - h_s);
      dy_mv = neg_sat(dy);
    end else begin
      y0_mv = ny[YW-1:0];
    end
  end

  // Rectangle registers: motion on frame_tick, then a config write overrides its field
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x0      <= RST_X0;
      y0      <= RST_Y0;
      w       <= RST_W;
      h       <= RST_H;
      color_q <= RST_COLOR;
      dx      <= '0;
      dy      <= '0;
      en      <= RST_EN;
    end else begin
      if (frame_tick && en) begin
        x0 <= x0_mv;
        y0 <= y0_mv;
        dx <= dx_mv;
        dy <= dy_mv;
      end
      if (wr_sel) begin
        case (cfg_field)
          FIELD_X0:    x0      <= cfg_data[XW-1:0];
          FIELD_Y0:    y0      <= cfg_data[YW-1:0];
          FIELD_W:     w       <= cfg_data[XW-1:0];
          FIELD_H:     h       <= cfg_data[YW-1:0];
          FIELD_COLOR: color_q <= cfg_data;
          FIELD_VEL: begin
            dx <= $signed(cfg_data[3:0]);
            dy <= $signed(cfg_data[7:4]);
          end
          FIELD_EN:    en      <= cfg_data[0];
          default:     ;
        endcase
      end
    end
  end

  // Half-open coverage test; sums are one bit wider so they cannot wrap
  assign cover_x = (x >= x0) && ({1'b0, x} < ({1'b0, x0} + {1'b0, w}));
  assign cover_y = (y >= y0) && ({1'b0, y} < ({1'b0, y0} + {1'b0, h}));

  // Stage 1: register whether this enabled rectangle covers the pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_s1 <= 1'b0;
    end else begin
      hit_s1 <= en && cover_x && cover_y;
    end
  end

endmodule

// File: rtl/shape_engine.sv
// Rectangle shape engine: N_RECT moving rectangles, lowest index drawn on
// top, two-cycle pixel pipeline from x/y to colour and hit.
module shape_engine
  import shapes_pkg::*;
#(
  parameter int N_RECT = 4,
  parameter int H_RES  = 640,
  parameter int V_RES  = 480
) (
  input logic           clk,
  input logic           rst_n,
  shape_engine_if.slave bus
);

  logic [N_RECT-1:0] hit_vec;
  logic [CW-1:0]     color_arr [N_RECT];
  logic [CW-1:0]     sel_color;
  logic              sel_hit;
  logic [CW-1:0]     out_color;
  logic              out_hit;

  for (genvar i = 0; i < N_RECT; i++) begin : g_rect
    shape_rect #(
      .IDX   (i),
      .H_RES (H_RES),
      .V_RES (V_RES)
    ) u_rect (
      .clk        (clk),
      .rst_n      (rst_n),
      .x          (bus.x),
      .y          (bus.y),
      .frame_tick (bus.frame_tick),
      .cfg_we     (bus.cfg_we),
      .cfg_idx    (bus.cfg_idx),
      .cfg_field  (bus.cfg_field),
      .cfg_data   (bus.cfg_data),
      .hit_s1     (hit_vec[i]),
      .color      (color_arr[i])
    );
  end

  // Pick the lowest-index covering rectangle by scanning from the top down
  always_comb begin
    sel_color = '0;
    sel_hit   = 1'b0;
    for (int i = N_RECT - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        sel_color = color_arr[i];
        sel_hit   = 1'b1;
      end
    end
  end

  // Stage 2: register the selected colour and the combined hit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_color <= '0;
      out_hit   <= 1'b0;
    end else begin
      out_color <= sel_color;
      out_hit   <= sel_hit;
    end
  end

  assign bus.r   = out_color[11:8];
  assign bus.g   = out_color[7:4];
  assign bus.b   = out_color[3:0];
  assign bus.hit = out_hit;

endmodule

// File: tb/tb_shape_engine.sv
// Directed bench for shape_engine: a table of pixel probes against a fixed
// scene, then hand-written sequences for motion, bounce and reset corners.
module tb_shape_engine;
  import shapes_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  shape_engine_if bus ();

  shape_engine #(
    .N_RECT (4),
    .H_RES  (640),
    .V_RES  (480)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [9:0]  x;
    logic [8:0]  y;
    logic [11:0] rgb;
    logic        hit;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input string name, input logic [9:0] px, input logic [8:0] py,
                         input logic [11:0] rgb, input logic hit);
    vec_t v;
    v.name = name;
    v.x    = px;
    v.y    = py;
    v.rgb  = rgb;
    v.hit  = hit;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [11:0] exp_rgb, input logic exp_hit);
    logic [11:0] got;
    got = {bus.r, bus.g, bus.b};
    checks++;
    if (got !== exp_rgb || bus.hit !== exp_hit) begin
      errors++;
      $display("[TB] FAIL %s: got rgb=%h hit=%b, expected rgb=%h hit=%b",
               name, got, bus.hit, exp_rgb, exp_hit);
    end
  endtask

  task automatic apply_stimulus(input logic [9:0] px, input logic [8:0] py);
    bus.x = px;
    bus.y = py;
    step();
    step();
  endtask

  task automatic probe(input string name, input logic [9:0] px, input logic [8:0] py,
                       input logic [11:0] rgb, input logic hit);
    apply_stimulus(px, py);
    check_output(name, rgb, hit);
  endtask

  task automatic cfg_write(input logic [2:0] idx, input logic [2:0] field, input logic [11:0] data);
    bus.cfg_we    = 1'b1;
    bus.cfg_idx   = idx;
    bus.cfg_field = field;
    bus.cfg_data  = data;
    step();
    bus.cfg_we    = 1'b0;
  endtask

  task automatic tick();
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    bus.x = 10'd150;
    bus.y = 9'd250;
    bus.frame_tick = 1'b0;
    bus.cfg_we = 1'b0;
    bus.cfg_idx = '0;
    bus.cfg_field = '0;
    bus.cfg_data = '0;

    // Reset holds outputs low, then the default rectangle appears two edges later
    step();
    step();
    step();
    check_output("reset_outputs", 12'h000, 1'b0);
    rst_n = 1'b1;
    step();
    step();
    check_output("resume_after_reset", 12'hFA4, 1'b1);

    // Scene: rect1 hidden under rect0, rect2 in the bottom-right corner
    cfg_write(3'd1, FIELD_X0, 12'd120);
    cfg_write(3'd1, FIELD_Y0, 12'd220);
    cfg_write(3'd1, FIELD_W, 12'd20);
    cfg_write(3'd1, FIELD_H, 12'd20);
    cfg_write(3'd1, FIELD_COLOR, 12'h0F0);
    cfg_write(3'd1, FIELD_EN, 12'd1);
    cfg_write(3'd2, FIELD_X0, 12'd600);
    cfg_write(3'd2, FIELD_Y0, 12'd400);
    cfg_write(3'd2, FIELD_W, 12'd40);
    cfg_write(3'd2, FIELD_H, 12'd80);
    cfg_write(3'd2, FIELD_COLOR, 12'h123);
    cfg_write(3'd2, FIELD_EN, 12'd1);

    add_vec("inside_r0",      10'd150, 9'd250, 12'hFA4, 1'b1);
    add_vec("right_excl",     10'd200, 9'd250, 12'h000, 1'b0);
    add_vec("last_pixel_r0",  10'd199, 9'd299, 12'hFA4, 1'b1);
    add_vec("corner_r0",      10'd100, 9'd200, 12'hFA4, 1'b1);
    add_vec("left_outside",   10'd99,  9'd250, 12'h000, 1'b0);
    add_vec("bottom_excl",    10'd150, 9'd300, 12'h000, 1'b0);
    add_vec("priority_r0",    10'd130, 9'd230, 12'hFA4, 1'b1);
    add_vec("r2_far_corner",  10'd639, 9'd479, 12'h123, 1'b1);
    add_vec("r2_near_corner", 10'd600, 9'd400, 12'h123, 1'b1);
    add_vec("r2_left_out",    10'd599, 9'd400, 12'h000, 1'b0);
    add_vec("origin_empty",   10'd0,   9'd0,   12'h000, 1'b0);
    foreach (vecs[i]) begin
      probe(vecs[i].name, vecs[i].x, vecs[i].y, vecs[i].rgb, vecs[i].hit);
    end

    // Disabling rect0 exposes rect1; an out-of-range index must not re-enable it
    cfg_write(3'd0, FIELD_EN, 12'd0);
    probe("r1_exposed", 10'd130, 9'd230, 12'h0F0, 1'b1);
    cfg_write(3'd4, FIELD_EN, 12'd1);
    probe("bad_idx_ignored", 10'd130, 9'd230, 12'h0F0, 1'b1);

    // Right-edge bounce: 538+5+100 > 640 -> x0=540, dx=-5, then 535
    do_reset();
    cfg_write(3'd0, FIELD_X0, 12'd538);
    cfg_write(3'd0, FIELD_VEL, 12'h005);
    tick();
    probe("bounce_r_in", 10'd540, 9'd250, 12'hFA4, 1'b1);
    probe("bounce_r_out", 10'd539, 9'd250, 12'h000, 1'b0);
    tick();
    probe("after_bounce_in", 10'd535, 9'd250, 12'hFA4, 1'b1);
    probe("after_bounce_out", 10'd534, 9'd250, 12'h000, 1'b0);
    probe("after_bounce_end", 10'd635, 9'd250, 12'h000, 1'b0);

    // Left-edge bounce: 1-3 < 0 -> x0=0, dx=+3, then 3
    cfg_write(3'd0, FIELD_X0, 12'd1);
    cfg_write(3'd0, FIELD_VEL, 12'h00D);
    tick();
    probe("bounce_l_in", 10'd0, 9'd250, 12'hFA4, 1'b1);
    probe("bounce_l_end", 10'd100, 9'd250, 12'h000, 1'b0);
    tick();
    probe("after_l_in", 10'd3, 9'd250, 12'hFA4, 1'b1);
    probe("after_l_out", 10'd2, 9'd250, 12'h000, 1'b0);

    // Zero width never covers: sweep a full row and a full column
    cfg_write(3'd0, FIELD_W, 12'd0);
    for (int i = 0; i < 642 + 482; i++) begin
      if (i < 640) begin
        bus.x = 10'(i);
        bus.y = 9'd250;
      end else if (i < 1120) begin
        bus.x = 10'd3;
        bus.y = 9'(i - 640);
      end
      step();
      if (i >= 2) begin
        checks++;
        if (bus.hit !== 1'b0) begin
          errors++;
          $display("[TB] FAIL w0_sweep step %0d: got hit=%b, expected hit=0", i, bus.hit);
        end
      end
    end

    // dy=-8 bounces off the top and saturates to +7: y0 4 -> 0 -> 7
    cfg_write(3'd0, FIELD_W, 12'd100);
    cfg_write(3'd0, FIELD_Y0, 12'd4);
    cfg_write(3'd0, FIELD_VEL, 12'h080);
    tick();
    probe("top_bounce", 10'd50, 9'd0, 12'hFA4, 1'b1);
    tick();
    probe("sat_out", 10'd50, 9'd6, 12'h000, 1'b0);
    probe("sat_in", 10'd50, 9'd7, 12'hFA4, 1'b1);

    // Config write coincides with frame_tick: X0 write wins, y still moves
    do_reset();
    cfg_write(3'd0, FIELD_VEL, 12'h014);
    bus.frame_tick = 1'b1;
    cfg_write(3'd0, FIELD_X0, 12'd10);
    bus.frame_tick = 1'b0;
    probe("coincide_in", 10'd10, 9'd201, 12'hFA4, 1'b1);
    probe("coincide_x_out", 10'd9, 9'd201, 12'h000, 1'b0);
    probe("coincide_y_out", 10'd10, 9'd200, 12'h000, 1'b0);

    // Mid-cycle reset clears outputs at once and restores rect0 defaults
    do_reset();
    cfg_write(3'd0, FIELD_X0, 12'd120);
    probe("pre_reset_hit", 10'd150, 9'd250, 12'hFA4, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async_reset_clear", 12'h000, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    check_output("no_early_resume", 12'h000, 1'b0);
    step();
    check_output("resume_2_cycles", 12'hFA4, 1'b1);
    probe("default_x0_in", 10'd100, 9'd200, 12'hFA4, 1'b1);
    probe("default_x0_out", 10'd99, 9'd200, 12'h000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
